// File: rtl/led_pattern_seq.sv
// led_pattern_seq: steps through a small pattern table and drives the selected
// pattern onto the LEDs. A prescaler sets the step rate. The index walks the
// table in wrap, bounce, one-shot or hold mode.
// Build option: define LED_PAT_WRITE_EN to make the pattern table writable
// through wr_en/wr_addr/wr_data. Without it, the table is a constant one-hot walk.
module led_pattern_seq #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 3,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  period,
  input  logic              restart,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  led_out,
  output logic [ADDR_W-1:0] step_idx,
  output logic              done
);

  localparam int N = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_LAST = '1;
  localparam logic [ADDR_W-1:0] IDX_PEN  = IDX_LAST - 1'b1;
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_BOUNCE  = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_e;

  // Power-up table contents: a one-hot walk across the LEDs.
  function automatic logic [WIDTH-1:0] init_pat(input int i);
    return WIDTH'(1) << (i % WIDTH);
  endfunction

  mode_e                cur_mode;
  logic [DIV_W-1:0]     cnt;
  logic                 tick;
  logic [ADDR_W-1:0]    idx, idx_d;
  logic                 dir_up, dir_d;
  logic                 done_d;
  logic [WIDTH-1:0]     rd_data;

  assign cur_mode = mode_e'(mode);
  assign tick     = en && (cnt == period);
  assign step_idx = idx;

  // Prescaler: count 0..period while enabled, and emit a tick on the final count.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so that every flop samples pre-edge values.
    if (!rst_n)        cnt <= '0;
    else if (restart)  cnt <= '0;
    else if (en)       cnt <= tick ? '0 : cnt + 1'b1;
  end

  // Next index, direction and done flag for the current mode.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    idx_d  = idx;
    dir_d  = dir_up;
    done_d = done;
    if (cur_mode != MODE_ONESHOT) done_d = 1'b0;
    if (restart) begin
      idx_d  = '0;
      dir_d  = 1'b1;
      done_d = 1'b0;
    end else if (tick) begin
      unique case (cur_mode)
        MODE_WRAP: idx_d = idx + 1'b1;
        MODE_BOUNCE: begin
          if (dir_up) begin
            if (idx == IDX_LAST) begin
              idx_d = idx - 1'b1;
              dir_d = 1'b0;
            end else begin
              idx_d = idx + 1'b1;
              dir_d = (idx != IDX_PEN);
            end
          end else begin
            if (idx == '0) begin
              idx_d = idx + 1'b1;
              dir_d = 1'b1;
            end else begin
              idx_d = idx - 1'b1;
              dir_d = (idx == IDX_ONE);
            end
          end
        end
        MODE_ONESHOT: begin
          if (!done) begin
            if (idx == IDX_LAST) begin
              done_d = 1'b1;
            end else begin
              idx_d  = idx + 1'b1;
              done_d = (idx == IDX_PEN);
            end
          end
        end
        MODE_HOLD: ;
        default: ;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      dir_up <= 1'b1;
      done   <= 1'b0;
    end else begin
      idx    <= idx_d;
      dir_up <= dir_d;
      done   <= done_d;
    end
  end

`ifdef LED_PAT_WRITE_EN
  logic [WIDTH-1:0] pat_mem [N];

  // Writable pattern table, reloaded with the one-hot walk on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the table is reset in place, so every run starts from a known pattern; this keeps it in flops, not RAM.
    if (!rst_n) begin
      for (int i = 0; i < N; i++) pat_mem[i] <= init_pat(i);
    end else if (wr_en) begin
      pat_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = pat_mem[idx];
`else
  logic unused_wr;

  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign rd_data   = init_pat(int'(idx));
`endif

  // Registered LED drive; it follows the table entry selected by the current index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_out <= '0;
    else        led_out <= rd_data;
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed testbench for led_pattern_seq (WIDTH=4, ADDR_W=3, DIV_W=16).
// Covers reset, wrap, bounce, mid-run reset, one-shot with restart priority,
// enable freeze, hold mode, and the table write path.
module tb_led_pattern_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] period;
  logic        restart;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [3:0]  wr_data;
  logic [3:0]  led_out;
  logic [2:0]  step_idx;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  led_pattern_seq #(.WIDTH(4), .ADDR_W(3), .DIV_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .period   (period),
    .restart  (restart),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .led_out  (led_out),
    .step_idx (step_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int bexp [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int prev;

    rst_n = 1'b0; en = 1'b0; mode = 2'b00; period = 16'd0; restart = 1'b0;
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;

    // Reset state.
    #12;
    chk("rst_led", 32'(led_out), 32'h0);
    chk("rst_idx", 32'(step_idx), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    step(1);

    // Wrap mode with period 0: the index advances every edge, and led_out lags by one cycle.
    en = 1'b1; mode = 2'b00; period = 16'd0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("wrap_idx", 32'(step_idx), 32'(k % 8));
      chk("wrap_led", 32'(led_out), 32'(4'b0001 << ((k - 1) % 4)));
    end

    // Restart, then bounce mode with period 2.
    restart = 1'b1; mode = 2'b01; period = 16'd2;
    step(1);
    restart = 1'b0;
    chk("restart_idx", 32'(step_idx), 32'h0);
    prev = 0;
    for (int j = 0; j < 16; j++) begin
      step(2);
      chk("bounce_hold", 32'(step_idx), 32'(prev));
      step(1);
      chk("bounce_step", 32'(step_idx), 32'(bexp[j]));
      prev = bexp[j];
    end

    // Mid-run reset clears all outputs without a clock edge.
    rst_n = 1'b0;
    #1;
    chk("arst_led", 32'(led_out), 32'h0);
    chk("arst_idx", 32'(step_idx), 32'h0);
    chk("arst_done", 32'(done), 32'h0);
    period = 16'd3; mode = 2'b01; en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(3);
    chk("rel_idx_c3", 32'(step_idx), 32'h0);
    step(1);
    chk("rel_idx_c4", 32'(step_idx), 32'h1);

    // One-shot mode with period 0.
    restart = 1'b1; mode = 2'b10; period = 16'd0;
    step(1);
    restart = 1'b0;
    chk("os_start_idx", 32'(step_idx), 32'h0);
    step(6);
    chk("os_idx6", 32'(step_idx), 32'h6);
    chk("os_done6", 32'(done), 32'h0);
    step(1);
    chk("os_idx7", 32'(step_idx), 32'h7);
    chk("os_done7", 32'(done), 32'h1);
    step(3);
    chk("os_idx_held", 32'(step_idx), 32'h7);
    chk("os_done_held", 32'(done), 32'h1);
    chk("os_led_held", 32'(led_out), 32'h8);

    // The restart pulse coincides with a tick (period 0, en 1); restart takes priority.
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("prio_idx", 32'(step_idx), 32'h0);
    chk("prio_done", 32'(done), 32'h0);

    // Wrap to index 3, then freeze with en low.
    mode = 2'b00;
    step(3);
    chk("pre_freeze_idx", 32'(step_idx), 32'h3);
    chk("wrap_done_clr", 32'(done), 32'h0);
    en = 1'b0;
    step(10);
    chk("freeze_idx", 32'(step_idx), 32'h3);
    chk("freeze_led", 32'(led_out), 32'h8);

    // Write 1111 to the current index while frozen.
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hF;
    step(1);
    wr_en = 1'b0;
    chk("wr_led_c1", 32'(led_out), 32'h8);
    step(1);
`ifdef LED_PAT_WRITE_EN
    chk("wr_led_c2", 32'(led_out), 32'hF);
`else
    chk("wr_led_c2", 32'(led_out), 32'h8);
`endif

    // Hold mode: the prescaler runs but the index stays put.
    en = 1'b1; mode = 2'b11;
    step(5);
    chk("hold_idx", 32'(step_idx), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
